// File: rtl/mips_control_unit.sv
// Multicycle Moore control unit for the 16-bit MIPS-style core (4-bit opcode, 3-bit funk).
// Latency: outputs decode from the registered state; each instruction takes 3-5 cycles from FETCH.
// Backpressure: none; the FSM advances on every rising CLK edge while Reset is high.
//
// Ports:
//   CLK, Reset          clock (rising edge) and asynchronous active-low reset
//   Opcode, funk        IR fields; sampled only in DECODE and MEM_ADDR
//   ALUOp .. BranchCond datapath mux selects, write enables and ALU op code
//   current_state       registered state (debug)
//   next_state          combinational next state (debug)
module mips_control_unit (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [3:0] Opcode,
  input  logic [2:0] funk,
  output logic [1:0] ALUOp,
  output logic       SrcA,
  output logic [1:0] SrcB,
  output logic [1:0] MemtoReg,
  output logic       RegDest,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic [1:0] PCSrc,
  output logic       MemSrc,
  output logic       OutputWrite,
  output logic       BranchCond,
  output logic [4:0] current_state,
  output logic [4:0] next_state
);

  typedef enum logic [4:0] {
    S_FETCH    = 5'd0,
    S_DECODE   = 5'd1,
    S_RTYPE_EX = 5'd2,
    S_RTYPE_WB = 5'd3,
    S_IMM_EX   = 5'd4,
    S_IMM_WB   = 5'd5,
    S_MEM_ADDR = 5'd6,
    S_LW_READ  = 5'd7,
    S_LW_WB    = 5'd8,
    S_SW_WRITE = 5'd9,
    S_BRANCH   = 5'd10,
    S_JUMP     = 5'd11,
    S_JAL      = 5'd12,
    S_JR       = 5'd13,
    S_IN       = 5'd14,
    S_OUT      = 5'd15
  } state_t;

  state_t state_q;
  state_t state_d;

  assign current_state = state_q;
  assign next_state    = state_d;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Gated by Reset so next_state also reads 0 while reset
  // is held, not just the registered state.
  always_comb begin
    state_d = S_FETCH;
    if (Reset) begin
      case (state_q)
        S_FETCH:    state_d = S_DECODE;
        S_DECODE: begin
          case (Opcode)
            4'b0000:          state_d = S_RTYPE_EX;
            4'b0001:          state_d = S_IMM_EX;
            4'b0010, 4'b0011: state_d = S_MEM_ADDR;
            4'b0111, 4'b1000: state_d = S_BRANCH;
            4'b1001:          state_d = S_JUMP;
            4'b1010:          state_d = S_JAL;
            4'b1011:          state_d = S_JR;
            4'b1100: begin
              if (funk == 3'b000)      state_d = S_IN;
              else if (funk == 3'b001) state_d = S_OUT;
              else                     state_d = S_FETCH;
            end
            default:          state_d = S_FETCH; // unused opcode executes as NOP
          endcase
        end
        S_RTYPE_EX: state_d = S_RTYPE_WB;
        S_IMM_EX:   state_d = S_IMM_WB;
        S_MEM_ADDR: begin
          if (Opcode == 4'b0010)      state_d = S_LW_READ;
          else if (Opcode == 4'b0011) state_d = S_SW_WRITE;
          else                        state_d = S_FETCH;
        end
        S_LW_READ:  state_d = S_LW_WB;
        default:    state_d = S_FETCH; // write-back/terminal states and illegal 16-31
      endcase
    end
  end

  // Moore output decode; everything defaults to 0 and reset forces all-zero
  // even though the registered state reads FETCH during reset.
  always_comb begin
    ALUOp       = 2'b00;
    SrcA        = 1'b0;
    SrcB        = 2'b00;
    MemtoReg    = 2'b00;
    RegDest     = 1'b0;
    RegWrite    = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCSrc       = 2'b00;
    MemSrc      = 1'b0;
    OutputWrite = 1'b0;
    BranchCond  = 1'b0;
    if (Reset) begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          SrcB    = 2'b01;
        end
        S_DECODE: begin
          SrcB = 2'b11; // branch target precomputed into ALUOut
        end
        S_RTYPE_EX: begin
          SrcA  = 1'b1;
          ALUOp = 2'b10;
        end
        S_RTYPE_WB: begin
          RegWrite = 1'b1;
          RegDest  = 1'b1;
        end
        S_IMM_EX: begin
          SrcA  = 1'b1;
          SrcB  = 2'b10;
          ALUOp = 2'b11;
        end
        S_IMM_WB: begin
          RegWrite = 1'b1;
        end
        S_MEM_ADDR: begin
          SrcA = 1'b1;
          SrcB = 2'b10;
        end
        S_LW_READ: begin
          MemRead = 1'b1;
          MemSrc  = 1'b1;
        end
        S_LW_WB: begin
          RegWrite = 1'b1;
          MemtoReg = 2'b01;
        end
        S_SW_WRITE: begin
          MemWrite = 1'b1;
          MemSrc   = 1'b1;
        end
        S_BRANCH: begin
          SrcA       = 1'b1;
          ALUOp      = 2'b01;
          PCSrc      = 2'b01;
          BranchCond = 1'b1;
        end
        S_JUMP: begin
          PCWrite = 1'b1;
          PCSrc   = 2'b10;
        end
        S_JAL: begin
          PCWrite  = 1'b1;
          PCSrc    = 2'b10;
          RegWrite = 1'b1;
          MemtoReg = 2'b10; // datapath selects the link register for this case
        end
        S_JR: begin
          PCWrite = 1'b1;
          PCSrc   = 2'b11;
          SrcA    = 1'b1;
        end
        S_IN: begin
          RegWrite = 1'b1;
          MemtoReg = 2'b11;
        end
        S_OUT: begin
          OutputWrite = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_control_unit.sv
// Directed testbench for mips_control_unit: walks every instruction class and checks
// state, next_state and the full control-output word at each cycle, plus reset behaviour.
module tb_mips_control_unit;

  logic       CLK;
  logic       Reset;
  logic [3:0] Opcode;
  logic [2:0] funk;
  logic [1:0] ALUOp;
  logic       SrcA;
  logic [1:0] SrcB;
  logic [1:0] MemtoReg;
  logic       RegDest;
  logic       RegWrite;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       PCWrite;
  logic [1:0] PCSrc;
  logic       MemSrc;
  logic       OutputWrite;
  logic       BranchCond;
  logic [4:0] current_state;
  logic [4:0] next_state;

  int errors = 0;
  int checks = 0;

  mips_control_unit dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .funk(funk),
    .ALUOp(ALUOp), .SrcA(SrcA), .SrcB(SrcB), .MemtoReg(MemtoReg),
    .RegDest(RegDest), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCSrc(PCSrc), .MemSrc(MemSrc), .OutputWrite(OutputWrite),
    .BranchCond(BranchCond), .current_state(current_state),
    .next_state(next_state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Packed control word: ALUOp SrcA SrcB MemtoReg RegDest RegWrite MemRead
  // MemWrite IRWrite PCWrite PCSrc MemSrc OutputWrite BranchCond (18 bits).
  function automatic logic [17:0] outs_now();
    return {ALUOp, SrcA, SrcB, MemtoReg, RegDest, RegWrite, MemRead,
            MemWrite, IRWrite, PCWrite, PCSrc, MemSrc, OutputWrite, BranchCond};
  endfunction

  // Expected outputs per state, transcribed from the state table.
  function automatic logic [17:0] outs_for(input int s);
    logic [1:0] aluop, srcb, m2r, pcsrc;
    logic srca, rdst, rw, mr, mw, irw, pcw, msrc, ow, bc;
    aluop = 2'b00; srcb = 2'b00; m2r = 2'b00; pcsrc = 2'b00;
    srca = 0; rdst = 0; rw = 0; mr = 0; mw = 0; irw = 0; pcw = 0;
    msrc = 0; ow = 0; bc = 0;
    case (s)
      0:  begin mr = 1; irw = 1; pcw = 1; srcb = 2'b01; end
      1:  begin srcb = 2'b11; end
      2:  begin srca = 1; aluop = 2'b10; end
      3:  begin rw = 1; rdst = 1; end
      4:  begin srca = 1; srcb = 2'b10; aluop = 2'b11; end
      5:  begin rw = 1; end
      6:  begin srca = 1; srcb = 2'b10; end
      7:  begin mr = 1; msrc = 1; end
      8:  begin rw = 1; m2r = 2'b01; end
      9:  begin mw = 1; msrc = 1; end
      10: begin srca = 1; aluop = 2'b01; pcsrc = 2'b01; bc = 1; end
      11: begin pcw = 1; pcsrc = 2'b10; end
      12: begin pcw = 1; pcsrc = 2'b10; rw = 1; m2r = 2'b10; end
      13: begin pcw = 1; pcsrc = 2'b11; srca = 1; end
      14: begin rw = 1; m2r = 2'b11; end
      15: begin ow = 1; end
      default: begin end
    endcase
    return {aluop, srca, srcb, m2r, rdst, rw, mr, mw, irw, pcw, pcsrc, msrc, ow, bc};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input int cur, input int nxt);
    chk($sformatf("cur_state@%0d", cur), {27'd0, current_state}, cur);
    chk($sformatf("next_state@%0d", cur), {27'd0, next_state}, nxt);
    chk($sformatf("outputs@%0d", cur), {14'd0, outs_now()}, {14'd0, outs_for(cur)});
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cur"}, {27'd0, current_state}, 32'd0);
    chk({tag, "_next"}, {27'd0, next_state}, 32'd0);
    chk({tag, "_outs"}, {14'd0, outs_now()}, 32'd0);
  endtask

  // Advance one rising edge and sample on the following falling edge.
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    Reset  = 1'b0;
    Opcode = 4'b0000;
    funk   = 3'b000;
    #2;
    chk_reset("rst_early");
    @(negedge CLK);
    tick();                       // clock edges while reset held
    chk_reset("rst_held");
    Reset = 1'b1;
    #1;
    chk_state(0, 1);

    // R-type; opcode changes in RTYPE_EX must not redirect the FSM
    tick(); chk_state(1, 2);
    tick(); Opcode = 4'b0010; #1; chk_state(2, 3);
    tick(); chk_state(3, 0);

    // lw (Opcode already 0010)
    tick(); chk_state(0, 1);
    tick(); chk_state(1, 6);
    tick(); chk_state(6, 7);
    tick(); chk_state(7, 8);
    tick(); chk_state(8, 0);

    // sw
    Opcode = 4'b0011;
    tick(); chk_state(0, 1);
    tick(); chk_state(1, 6);
    tick(); chk_state(6, 9);
    tick(); chk_state(9, 0);

    // immediate
    Opcode = 4'b0001;
    tick(); chk_state(0, 1);
    tick(); chk_state(1, 4);
    tick(); chk_state(4, 5);
    tick(); chk_state(5, 0);

    // branches 0111 and 1000
    Opcode = 4'b0111;
    tick(); chk_state(0, 1);
    tick(); chk_state(1, 10);
    tick(); chk_state(10, 0);
    Opcode = 4'b1000;
    tick(); chk_state(0, 1);
    tick(); chk_state(1, 10);
    tick(); chk_state(10, 0);

    // j, jal, jr
    Opcode = 4'b1001;
    tick(); chk_state(0, 1);
    tick(); chk_state(1, 11);
    tick(); chk_state(11, 0);
    Opcode = 4'b1010;
    tick(); chk_state(0, 1);
    tick(); chk_state(1, 12);
    tick(); chk_state(12, 0);
    Opcode = 4'b1011;
    tick(); chk_state(0, 1);
    tick(); chk_state(1, 13);
    tick(); chk_state(13, 0);

    // in / out / bad funk
    Opcode = 4'b1100; funk = 3'b000;
    tick(); chk_state(0, 1);
    tick(); chk_state(1, 14);
    tick(); chk_state(14, 0);
    funk = 3'b001;
    tick(); chk_state(0, 1);
    tick(); chk_state(1, 15);
    tick(); chk_state(15, 0);
    funk = 3'b010;
    tick(); chk_state(0, 1);
    tick(); chk_state(1, 0);

    // unused opcode acts as NOP
    Opcode = 4'b0101; funk = 3'b000;
    tick(); chk_state(0, 1);
    tick(); chk_state(1, 0);
    tick(); chk_state(0, 1);

    // lw interrupted by reset in LW_READ: abort without waiting for an edge
    Opcode = 4'b0010;
    tick(); chk_state(1, 6);
    tick(); chk_state(6, 7);
    tick(); chk_state(7, 8);
    Reset = 1'b0;
    #1;
    chk_reset("rst_mid");
    tick();
    chk_reset("rst_mid_held");
    Reset = 1'b1;
    #1;
    chk_state(0, 1);
    tick(); chk_state(1, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_control_unit.md
Name: mips_control_unit

Overview:
- Multicycle Moore FSM control unit for the team's 16-bit MIPS-style processor, with a 4-bit opcode and a 3-bit function field.
- Sits beside the datapath and drives every mux select, write enable and ALU-operation code from the current state.
- Each instruction takes 3–5 cycles, starting from FETCH.
- Exposes current and next state for debug.

Parameters:
- none. State encoding is fixed at 5 bits.

Ports:
- CLK  in  1  system clock; rising-edge.
- Reset  in  1  asynchronous, active-low reset.
- Opcode  in  4  IR opcode field.
- funk  in  3  IR function field; used for opcode 1100 only.
- ALUOp  out  2  ALU operation: 00 add, 01 subtract, 10 per R-type funct, 11 per immediate opcode.
- SrcA  out  1  ALU A select: 0 PC, 1 register A.
- SrcB  out  2  ALU B select: 00 register B, 01 constant 1, 10 sign-extended immediate, 11 branch offset.
- MemtoReg  out  2  register write-data select: 00 ALUOut, 01 memory data, 10 PC (link), 11 input port.
- RegDest  out  1  destination register: 1 rd, 0 rt.
- RegWrite  out  1  register-file write enable.
- MemRead  out  1  memory read.
- MemWrite  out  1  memory write.
- IRWrite  out  1  instruction register load.
- PCWrite  out  1  unconditional PC write.
- PCSrc  out  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target, 11 register A.
- MemSrc  out  1  memory address select: 0 PC, 1 ALUOut.
- OutputWrite  out  1  output-port register load.
- BranchCond  out  1  conditional PC-write strobe. The datapath writes PC when PCWrite, or when BranchCond and (Zero XOR IR[15]).
- current_state  out  5  registered state.
- next_state  out  5  combinational next state.

Behaviour:
- Reset low forces all of the following, asynchronously, regardless of CLK:
  - current_state = 0 (FETCH).
  - next_state = 0.
  - every control output = 0.
- After Reset rises, the first rising CLK edge loads next_state into current_state.
- Outputs decode from current_state only (Moore); any output not listed for a state is 0.
- States, with asserted outputs and transitions:
  - 0 FETCH: MemRead, IRWrite, PCWrite, SrcA=0, SrcB=01, ALUOp=00, PCSrc=00, MemSrc=0 → 1.
  - 1 DECODE: SrcA=0, SrcB=11, ALUOp=00 (precomputes branch target into ALUOut). Next state by Opcode:
    - 0000 → 2
    - 0001 → 4
    - 0010 or 0011 → 6
    - 0111 or 1000 → 10
    - 1001 → 11
    - 1010 → 12
    - 1011 → 13
    - 1100 with funk 000 → 14
    - 1100 with funk 001 → 15
    - any other opcode, or 1100 with any other funk → 0 (treated as NOP).
  - 2 RTYPE_EX: SrcA=1, SrcB=00, ALUOp=10 → 3.
  - 3 RTYPE_WB: RegWrite, RegDest=1, MemtoReg=00 → 0.
  - 4 IMM_EX: SrcA=1, SrcB=10, ALUOp=11 → 5.
  - 5 IMM_WB: RegWrite, RegDest=0, MemtoReg=00 → 0.
  - 6 MEM_ADDR: SrcA=1, SrcB=10, ALUOp=00. Opcode 0010 → 7; opcode 0011 → 9.
  - 7 LW_READ: MemRead, MemSrc=1 → 8.
  - 8 LW_WB: RegWrite, RegDest=0, MemtoReg=01 → 0.
  - 9 SW_WRITE: MemWrite, MemSrc=1 → 0.
  - 10 BRANCH: SrcA=1, SrcB=00, ALUOp=01, PCSrc=01, BranchCond → 0.
  - 11 JUMP: PCWrite, PCSrc=10 → 0.
  - 12 JAL: PCWrite, PCSrc=10, RegWrite, MemtoReg=10 → 0. The datapath hardwires the link register when MemtoReg=10.
  - 13 JR: PCWrite, PCSrc=11, SrcA=1 → 0.
  - 14 IN: RegWrite, RegDest=0, MemtoReg=11 → 0.
  - 15 OUT: OutputWrite → 0.
  - Encodings 16–31 are illegal: all outputs 0, next_state = 0.
- Opcode and funk are sampled only in DECODE and MEM_ADDR; changes at other times have no effect.
- Reset asserted mid-instruction aborts immediately. When released, the FSM resumes at FETCH.
- Cycle counts from FETCH:
  - lw: 5
  - R-type, immediate, sw: 4
  - branch, j, jal, jr, in, out: 3

Test Plan:
- Opcode=0000, funk=0; pulse Reset low then high; clock 5 cycles → current_state 0,1,2,3,0. RegWrite=1 and RegDest=1 only in state 3. Verify all outputs are 0 while Reset is low.
- Opcode=0010 → states 0,1,6,7,8. In state 7: MemRead=1, MemSrc=1. In state 8: RegWrite=1, MemtoReg=01. Then with Opcode=0011 → 0,1,6,9,0, with MemWrite=1 in state 9.
- Opcode=0111 and 1000 → 0,1,10,0. In state 10: BranchCond=1, ALUOp=01, PCSrc=01, PCWrite=0.
- Opcodes 1001, 1010, 1011 → states 11, 12 and 13 respectively, with PCSrc 10, 10 and 11 and PCWrite=1. State 12 also asserts RegWrite with MemtoReg=10.
- Opcode=1100 with funk=000 → state 14 (RegWrite=1, MemtoReg=11). funk=001 → state 15 (OutputWrite=1). funk=010 → DECODE returns to 0.
- Unused opcode 0101 → 0,1,0 loop. Reset driven low in state 7 → current_state=0 immediately, without waiting for a clock edge.
